hls_deadlock_report: RTL and testbench

//  Downstream consumer of the HLS deadlock monitor tree (block / axis_block_info).

---
 rtl/hls_deadlock_report.sv | 158 +++++++++++++++
 tb/tb_hls_deadlock_report.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_report.sv
// hls_deadlock_report
// Qualifies the deadlock monitor's block flag as persistent (THRESH consecutive
// cycles) and latches a sticky report: blocked-channel info, free-run timestamp
// of the first cycle of the qualifying run, and how long the block has lasted
// since declaration. The interrupt stays high until software pulses clear.
module hls_deadlock_report #(
  parameter int INFO_W = 9,
  parameter int THRESH = 1024,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              block_in,
  input  logic [INFO_W-1:0] block_info_in,
  output logic              deadlock,
  output logic              irq,
  output logic              block_active,
  output logic [INFO_W-1:0] info_latched,
  output logic [CNT_W-1:0]  onset_stamp,
  output logic [CNT_W-1:0]  duration,
  output logic [1:0]        state
);

  localparam int RUN_W = $clog2(THRESH + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LATCHED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [CNT_W-1:0]    cand_q, cand_d;
  logic [INFO_W-1:0]   info_q, info_d;
  logic [CNT_W-1:0]    onset_q, onset_d;
  logic [CNT_W-1:0]    dur_q, dur_d;
  logic [CNT_W-1:0]    free_q;
  logic                blk_q;

  // Free-running timestamp counter; wraps and never stops.
  always_ff @(posedge clock) begin
    if (reset) begin
      free_q <= '0;
    end else begin
      free_q <= free_q + CNT_W'(1);
    end
  end

  // One-cycle delayed copy of the monitor's block flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      blk_q <= 1'b0;
    end else begin
      blk_q <= block_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run counter, onset candidate and latched report registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_q   <= '0;
      cand_q  <= '0;
      info_q  <= '0;
      onset_q <= '0;
      dur_q   <= '0;
    end else begin
      run_q   <= run_d;
      cand_q  <= cand_d;
      info_q  <= info_d;
      onset_q <= onset_d;
      dur_q   <= dur_d;
    end
  end

  // Next-state and report update: qualify the block run, latch, count, clear.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cand_d  = cand_q;
    info_d  = info_q;
    onset_d = onset_q;
    dur_d   = dur_q;
    case (state_q)
      ST_IDLE: begin
        run_d = '0;
        if (enable && block_in && !clear) begin
          cand_d = free_q;
          if (THRESH == 1) begin
            // A single qualifying sample is already the declaring one.
            state_d = ST_LATCHED;
            info_d  = block_info_in;
            onset_d = free_q;
            dur_d   = CNT_W'(1);
          end else begin
            state_d = ST_PENDING;
            run_d   = RUN_W'(1);
          end
        end
      end
      ST_PENDING: begin
        if (clear || !enable || !block_in) begin
          // Clear has priority even over the THRESH-th sample.
          state_d = ST_IDLE;
          run_d   = '0;
          cand_d  = '0;
        end else if (run_q + RUN_W'(1) == RUN_W'(THRESH)) begin
          state_d = ST_LATCHED;
          run_d   = '0;
          info_d  = block_info_in;
          onset_d = cand_q;
          dur_d   = CNT_W'(1);
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      ST_LATCHED: begin
        if (clear) begin
          state_d = ST_IDLE;
          run_d   = '0;
          cand_d  = '0;
          info_d  = '0;
          onset_d = '0;
          dur_d   = '0;
        end else if (block_in && (dur_q != '1)) begin
          dur_d = dur_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  // Outputs: sticky flag and interrupt follow the LATCHED state directly.
  always_comb begin
    deadlock     = (state_q == ST_LATCHED);
    irq          = (state_q == ST_LATCHED);
    block_active = blk_q;
    info_latched = info_q;
    onset_stamp  = onset_q;
    duration     = dur_q;
    state        = state_q;
  end

endmodule

// File: tb/tb_hls_deadlock_report.sv
// Scoreboard bench for hls_deadlock_report: two instances (THRESH=4/CNT_W=32 and
// THRESH=1/CNT_W=4) share the same stimulus; a cycle-level behavioural model
// pushes expected outputs, and a monitor pops and compares after each edge.
module tb_hls_deadlock_report;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       block_in = 1'b0;
  logic [8:0] block_info_in = '0;

  logic        a_deadlock, a_irq, a_block_active;
  logic [8:0]  a_info;
  logic [31:0] a_onset, a_duration;
  logic [1:0]  a_state;

  logic        b_deadlock, b_irq, b_block_active;
  logic [8:0]  b_info;
  logic [3:0]  b_onset, b_duration;
  logic [1:0]  b_state;

  hls_deadlock_report #(.INFO_W(9), .THRESH(4), .CNT_W(32)) u_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .block_in(block_in), .block_info_in(block_info_in),
    .deadlock(a_deadlock), .irq(a_irq), .block_active(a_block_active),
    .info_latched(a_info), .onset_stamp(a_onset), .duration(a_duration),
    .state(a_state)
  );

  hls_deadlock_report #(.INFO_W(9), .THRESH(1), .CNT_W(4)) u_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .block_in(block_in), .block_info_in(block_info_in),
    .deadlock(b_deadlock), .irq(b_irq), .block_active(b_block_active),
    .info_latched(b_info), .onset_stamp(b_onset), .duration(b_duration),
    .state(b_state)
  );

  typedef struct {
    logic        dl;
    logic        irq;
    logic        ba;
    logic [8:0]  info;
    logic [63:0] onset;
    logic [63:0] dur;
    logic [1:0]  st;
  } exp_t;

  // Model: length of the current qualifying run, a latched flag, and the report.
  typedef struct {
    int          run;
    logic [63:0] onset;
    bit          latched;
    logic [8:0]  info;
    logic [63:0] dur;
    logic [63:0] cyc;
    bit          blk;
  } model_t;

  model_t      m   [2];
  int          th  [2] = '{4, 1};
  logic [63:0] mx  [2] = '{64'hFFFF_FFFF, 64'hF};
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit en, input bit blk,
                            input bit clr, input logic [8:0] inf);
    if (rst) begin
      m[k].run = 0; m[k].onset = '0; m[k].latched = 0; m[k].info = '0;
      m[k].dur = '0; m[k].cyc = '0; m[k].blk = 0;
    end else begin
      if (!m[k].latched) begin
        if (clr || !en || !blk) begin
          m[k].run = 0;
        end else begin
          if (m[k].run == 0) m[k].onset = m[k].cyc;
          m[k].run++;
          if (m[k].run == th[k]) begin
            m[k].latched = 1;
            m[k].info    = inf;
            m[k].dur     = 64'd1;
            m[k].run     = 0;
          end
        end
      end else begin
        if (clr) begin
          m[k].latched = 0; m[k].info = '0; m[k].onset = '0; m[k].dur = '0;
        end else if (blk && m[k].dur != mx[k]) begin
          m[k].dur++;
        end
      end
      m[k].blk = blk;
      m[k].cyc = (m[k].cyc + 64'd1) & mx[k];
    end
  endtask

  function automatic exp_t expected(input int k);
    exp_t e;
    e.dl    = m[k].latched;
    e.irq   = m[k].latched;
    e.ba    = m[k].blk;
    e.info  = m[k].latched ? m[k].info : 9'h0;
    e.onset = m[k].latched ? m[k].onset : 64'h0;
    e.dur   = m[k].latched ? m[k].dur : 64'h0;
    e.st    = m[k].latched ? 2'd2 : (m[k].run > 0 ? 2'd1 : 2'd0);
    return e;
  endfunction

  task automatic step(input bit rst, input bit en, input bit blk, input bit clr,
                      input logic [8:0] inf);
    @(negedge clock);
    reset = rst; enable = en; block_in = blk; clear = clr; block_info_in = inf;
    model_step(0, rst, en, blk, clr, inf);
    model_step(1, rst, en, blk, clr, inf);
    q0.push_back(expected(0));
    q1.push_back(expected(1));
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  // Monitor: every edge the DUTs present a full output set to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("a_deadlock", 64'(a_deadlock), 64'(e.dl));
        chk("a_irq", 64'(a_irq), 64'(e.irq));
        chk("a_block_active", 64'(a_block_active), 64'(e.ba));
        chk("a_info", 64'(a_info), 64'(e.info));
        chk("a_onset", 64'(a_onset), e.onset);
        chk("a_duration", 64'(a_duration), e.dur);
        chk("a_state", 64'(a_state), 64'(e.st));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("b_deadlock", 64'(b_deadlock), 64'(e.dl));
        chk("b_irq", 64'(b_irq), 64'(e.irq));
        chk("b_block_active", 64'(b_block_active), 64'(e.ba));
        chk("b_info", 64'(b_info), 64'(e.info));
        chk("b_onset", 64'(b_onset), e.onset);
        chk("b_duration", 64'(b_duration), e.dur);
        chk("b_state", 64'(b_state), 64'(e.st));
      end
    end
  end

  // Stimulus: directed scenarios first, then a long randomized mix.
  initial begin
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 9'h0);

    // Cycles 0..9: a 3-cycle block that must not qualify at THRESH=4.
    for (int c = 0; c < 10; c++) step(0, 1, (c >= 2 && c <= 4), 0, 9'h0);
    settle();
    chk("dir_short_run_dl", 64'(a_deadlock), 64'd0);
    chk("dir_short_run_state", 64'(a_state), 64'd0);
    chk("dir_thresh1_latched", 64'(b_deadlock), 64'd1);

    // Cycles 10..13: qualifying run, info on declaring sample is 9'h1FB.
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 9'(510 - i));
    settle();
    chk("dir_latch_dl", 64'(a_deadlock), 64'd1);
    chk("dir_latch_irq", 64'(a_irq), 64'd1);
    chk("dir_latch_onset", 64'(a_onset), 64'd10);
    chk("dir_latch_info", 64'(a_info), 64'h1FB);

    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 9'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9'($urandom));
    settle();
    chk("dir_duration", 64'(a_duration), 64'd6);
    chk("dir_sticky_dl", 64'(a_deadlock), 64'd1);

    // Clear with block held high: report zeroed, fresh 4-sample run re-latches.
    step(0, 1, 1, 1, 9'h0AA);
    settle();
    chk("dir_clear_dl", 64'(a_deadlock), 64'd0);
    chk("dir_clear_dur", 64'(a_duration), 64'd0);
    chk("dir_clear_onset", 64'(a_onset), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 9'h055);
    settle();
    chk("dir_relatch_early", 64'(a_deadlock), 64'd0);
    step(0, 1, 1, 0, 9'h123);
    settle();
    chk("dir_relatch", 64'(a_deadlock), 64'd1);
    chk("dir_relatch_info", 64'(a_info), 64'h123);

    step(0, 1, 0, 1, 9'h0);
    step(0, 1, 0, 0, 9'h0);

    // Clear coincident with the 4th qualifying sample: no report.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 9'h0);
    step(0, 1, 1, 1, 9'h1FF);
    settle();
    chk("dir_clear_wins_state", 64'(a_state), 64'd0);
    chk("dir_clear_wins_dl", 64'(a_deadlock), 64'd0);
    step(0, 1, 0, 0, 9'h0);

    // Detection disarmed: long block must not latch.
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 9'h1AB);
    settle();
    chk("dir_disabled_dl", 64'(a_deadlock), 64'd0);
    chk("dir_disabled_state", 64'(a_state), 64'd0);

    // Randomized mix biased toward long block runs and rare clears.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 499) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 19) == 0),
           9'($urandom));
    end
    step(0, 1, 0, 0, 9'h0);
    settle();
    settle();
    chk("scoreboard_drain_a", 64'(q0.size()), 64'd0);
    chk("scoreboard_drain_b", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
